// File: rtl/sar_result_serializer_if.sv
// sar_result_serializer_if
//   Bundles the SAR-side capture signals and the serial pad signals of the
//   result serializer.
//   slave  : serializer view (captures conv_done/bitout/clr_ovf, drives pads)
//   master : SAR logic / pad side view
//   conv_done  one-cycle result strobe, bitout valid with it
//   bitout     WIDTH-bit conversion result
//   clr_ovf    synchronous clear of the sticky overflow flag
//   sclk/sdo/cs_n  SPI-style frame, MSB first, receiver samples on sclk rise
//   frame_done one-cycle pulse at frame end
//   fifo_count occupied FIFO entries
//   overflow   sticky "result dropped" flag
interface sar_result_serializer_if #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
);
  logic                     conv_done;
  logic [WIDTH-1:0]         bitout;
  logic                     clr_ovf;
  logic                     sclk;
  logic                     sdo;
  logic                     cs_n;
  logic                     frame_done;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     overflow;

  modport slave (
    input  conv_done, bitout, clr_ovf,
    output sclk, sdo, cs_n, frame_done, fifo_count, overflow
  );

  modport master (
    output conv_done, bitout, clr_ovf,
    input  sclk, sdo, cs_n, frame_done, fifo_count, overflow
  );
endinterface

// File: rtl/sar_result_serializer.sv
// sar_result_serializer
//   Captures each SAR result on conv_done into a DEPTH-entry FIFO and ships
//   it off-chip as an SPI-style frame, MSB first.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : sar_result_serializer_if.slave (capture inputs, serial pads,
//           frame_done, fifo_count, overflow)
//   Frame: SETUP (cs_n low, first bit on sdo) -> WIDTH x (HIGH, LOW) -> GAP,
//   each phase CLKDIV clk cycles, then one IDLE cycle that pops the next word.
module sar_result_serializer #(
  parameter int WIDTH  = 12,
  parameter int DEPTH  = 4,
  parameter int CLKDIV = 2
) (
  input logic                   clk,
  input logic                   reset,
  sar_result_serializer_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [BW-1:0] NBITS    = BW'(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_GAP} state_t;

  // FIFO
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  // Serializer
  state_t           r_state;
  logic [DW-1:0]    r_div;
  logic [BW-1:0]    r_bitcnt;
  logic [WIDTH-2:0] r_shreg;   // bits still to send; the MSB goes straight to sdo
  logic             r_sclk, r_sdo, r_cs_n, r_frame_done;

  logic             w_pop, w_push, w_drop, w_div_last;
  logic [WIDTH-1:0] w_head;

  // A full FIFO still accepts when the serializer pops the head this cycle.
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_push     = bus.conv_done && ((r_count != FULL) || w_pop);
  assign w_drop     = bus.conv_done && !w_push;
  assign w_div_last = (r_div == DIV_LAST);
  assign w_head     = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.bitout;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // a drop in the same cycle as a clear keeps the flag set
      if (w_drop)            r_overflow <= 1'b1;
      else if (bus.clr_ovf)  r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_div        <= '0;
      r_bitcnt     <= '0;
      r_shreg      <= '0;
      r_sclk       <= 1'b0;
      r_sdo        <= 1'b0;
      r_cs_n       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shreg  <= w_head[WIDTH-2:0];
            r_sdo    <= w_head[WIDTH-1];
            r_cs_n   <= 1'b0;
            r_div    <= '0;
            r_bitcnt <= '0;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_div_last) begin
            r_div    <= '0;
            r_sclk   <= 1'b1;
            r_bitcnt <= r_bitcnt + 1'b1;
            r_state  <= S_HIGH;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_HIGH: begin
          if (w_div_last) begin
            r_div   <= '0;
            r_sclk  <= 1'b0;
            r_state <= S_LOW;
            // next bit goes out on the falling edge; the last bit holds
            if (r_bitcnt != NBITS) begin
              r_sdo   <= r_shreg[WIDTH-2];
              r_shreg <= r_shreg << 1;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_LOW: begin
          if (w_div_last) begin
            r_div <= '0;
            if (r_bitcnt == NBITS) begin
              r_cs_n       <= 1'b1;
              r_sdo        <= 1'b0;
              r_frame_done <= 1'b1;
              r_state      <= S_GAP;
            end else begin
              r_sclk   <= 1'b1;
              r_bitcnt <= r_bitcnt + 1'b1;
              r_state  <= S_HIGH;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_GAP: begin
          if (w_div_last) begin
            r_div   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.sclk       = r_sclk;
  assign bus.sdo        = r_sdo;
  assign bus.cs_n       = r_cs_n;
  assign bus.frame_done = r_frame_done;
  assign bus.fifo_count = r_count;
  assign bus.overflow   = r_overflow;
endmodule

// File: doc/sar_result_serializer.md
Name: sar_result_serializer

Overview:
- Consumer end of the SAR conversion interface: captures each 12-bit result when the SAR FSM pulses `conv_done`.
- Buffers results in a small FIFO.
- Ships each result off-chip as an SPI-style frame, MSB first, with the block driving `sclk`, `cs_n` and `sdo`.
- Sits between the SAR logic and the chip output pads.

Parameters:
- WIDTH, 12: result word width.
- DEPTH, 4: FIFO entries; power of 2, at least 2.
- CLKDIV, 2: `sclk` half-period in `clk` cycles; at least 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- conv_done  in  1  one-cycle pulse from the SAR FSM; result valid on `bitout` in the same cycle.
- bitout  in  WIDTH  SAR conversion result.
- clr_ovf  in  1  synchronous clear of `overflow`.
- sclk  out  1  serial clock; idles low; receiver samples on the rising edge.
- sdo  out  1  serial data; changes only on the `sclk` falling edge or at frame start.
- cs_n  out  1  frame select, active low.
- frame_done  out  1  one-cycle pulse when a frame completes.
- fifo_count  out  clog2(DEPTH)+1  number of occupied FIFO entries.
- overflow  out  1  sticky flag: a result was dropped.

Behaviour:
- Reset (async assert, reset=0):
  - Outputs: `sclk`=0, `sdo`=0, `cs_n`=1, `frame_done`=0, `fifo_count`=0, `overflow`=0.
  - Internal: FSM goes to IDLE, FIFO pointers and divider counter clear.
  - Takes effect immediately, including mid-frame. Any partial frame is abandoned and never resent.
- Push:
  - Every clk with `conv_done`=1 writes `bitout`.
  - Accepted if FIFO not full, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and `overflow` is set.
  - `fifo_count` is updated one cycle after the push.
- Simultaneous push and pop: count unchanged; data order preserved.
- Overflow:
  - Stays set until `clr_ovf`=1.
  - If a drop and `clr_ovf` occur in the same cycle, set wins.
- FSM states:
  - IDLE:
    - `cs_n`=1, `sclk`=0, `sdo`=0.
    - If `fifo_count` > 0: pop the head into the shift register and go to SETUP next cycle.
  - SETUP:
    - `cs_n`=0, `sclk`=0, `sdo`=shreg[WIDTH-1].
    - Lasts CLKDIV cycles, then go to HIGH.
  - HIGH:
    - `sclk`=1 for CLKDIV cycles, then go to LOW.
    - Bit counter increments on entry.
  - LOW:
    - `sclk`=0 for CLKDIV cycles.
    - On entry, if bits remain: shreg shifts left and `sdo` presents the next bit.
    - At the end of the phase: return to HIGH if bits remain; after the WIDTH-th LOW, go to GAP.
    - The last bit holds `sdo` until GAP.
  - GAP:
    - `cs_n`=1, `sclk`=0, `sdo`=0.
    - `frame_done`=1 on the first GAP cycle only.
    - Lasts CLKDIV cycles, then IDLE.
- Frame timing:
  - `cs_n` low for exactly CLKDIV*(2*WIDTH+1) cycles.
  - Minimum frame-to-frame period is CLKDIV*(2*WIDTH+2)+1 cycles; 53 at the defaults.
- Latency: `cs_n` falls 2 clk after a `conv_done` cycle into an empty FIFO with the FSM in IDLE.
- Wrap-around:
  - FIFO pointers wrap modulo DEPTH.
  - The count distinguishes full from empty.
- `bitout` is not sampled outside `conv_done` cycles.

Test Plan:
- Single word: `bitout`=12'hA5C with a single `conv_done` pulse at cycle 0, CLKDIV=2.
  - `cs_n` falls at cycle 2 and stays low 50 cycles.
  - Receiver captures 1010_0101_1100 on 12 `sclk` rises.
  - `frame_done` pulses once; `fifo_count` returns to 0.
- Ordering: words 12'h001, 12'h800, 12'hFFF pushed 13 cycles apart.
  - Three frames in push order.
  - Each separated by `cs_n` high for 2 cycles plus an IDLE cycle; `overflow`=0.
- Overflow: 7 pushes at cycles 0, 5, …, 30 with values 1..7, DEPTH=4.
  - Word 1 popped at cycle 1; words 2–5 fill the FIFO.
  - Words 6 and 7 are dropped; `overflow`=1 from cycle 26.
  - Output frames are 1, 2, 3, 4, 5 only.
- Overflow clear race:
  - Pulse `clr_ovf` in the same cycle as a drop → `overflow` stays 1.
  - Pulse `clr_ovf` alone → 0 next cycle.
- Reset mid-frame: assert reset after the 5th `sclk` rise.
  - `cs_n`=1, `sclk`=0, `sdo`=0, `fifo_count`=0 without waiting for a clock edge.
  - After release, no frame until a new `conv_done`.
- CLKDIV=1, word 12'h3C3:
  - `cs_n` low exactly 25 cycles.
  - `sclk` toggles every cycle; correct bits sampled.
